bus_arbiter_split: RTL and testbench

Serial-bus arbiter and split-transaction scheduler for the shared single-bit bus (B_BUS_OUT/B_BUS_IN, B_ACK, B_RW) used by the memory slaves. It grants bus tenure to one of NUM_MASTERS requesters in round-robin order. It records a split when the addressed slave signals busy, and lends the bus to other masters while the split is pending. When the split slave reports ready, it re-grants the split master with B_SPL_RESUME so the slave leaves its HOLD state and completes the read.

---
 rtl/bus_arbiter_split.sv | 152 +++++++++++++++
 tb/tb_bus_arbiter_split.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_split.sv
// Round-robin arbiter for the shared serial bus with single-outstanding split tracking.
// A split master is parked until its slave reports ready, then re-granted with B_SPL_RESUME.
module bus_arbiter_split #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned NUM_SLAVES  = 3,
    parameter int unsigned MW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    parameter int unsigned SW          = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_MASTERS-1:0] M_REQ,
    output logic [NUM_MASTERS-1:0] M_GRANT,
    output logic [NUM_MASTERS-1:0] M_SPLIT,
    output logic [MW-1:0]          BUS_OWNER,
    input  logic [NUM_SLAVES-1:0]  SL_SEL,
    input  logic                   B_SBSY,
    input  logic [NUM_SLAVES-1:0]  SL_READY,
    output logic                   B_SPLIT,
    output logic                   B_SPL_RESUME,
    output logic                   SPLIT_OVF
);

    typedef enum logic [1:0] {StIdle, StGrant, StResume} state_e;

    state_e                   state_q, state_d;
    logic [MW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [MW-1:0]            owner_q, owner_d;
    logic                     split_valid_q, split_valid_d;
    logic [MW-1:0]            split_mst_q, split_mst_d;
    logic [SW-1:0]            split_slv_q, split_slv_d;
    logic                     ovf_q, ovf_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [NUM_MASTERS-1:0]   msplit_q, msplit_d;
    logic                     resume_q, resume_d;

    logic [NUM_MASTERS-1:0]   eligible;
    logic [2*NUM_MASTERS-1:0] rotated;
    int                       first_k;
    int                       pick_sum;
    logic [MW-1:0]            rr_pick;
    logic [MW-1:0]            rr_next;
    logic [SW-1:0]            sel_idx;
    logic                     slv_ready;

    function automatic logic [NUM_MASTERS-1:0] mst_onehot(input logic [MW-1:0] idx);
        return {{(NUM_MASTERS-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign eligible  = M_REQ & ~msplit_q;
    assign slv_ready = |(SL_READY & (NUM_SLAVES'(1) << split_slv_q));

    // Rotate the eligible set so bit 0 is rr_ptr, then take the lowest set bit.
    always_comb begin
        rotated = {eligible, eligible} >> rr_ptr_q;
        first_k = 0;
        for (int k = int'(NUM_MASTERS) - 1; k >= 0; k--) begin
            if (rotated[k]) first_k = k;
        end
        pick_sum = int'(rr_ptr_q) + first_k;
        if (pick_sum >= int'(NUM_MASTERS)) pick_sum = pick_sum - int'(NUM_MASTERS);
        rr_pick = MW'(pick_sum);
        rr_next = (32'(rr_pick) + 32'd1 == NUM_MASTERS) ? '0 : rr_pick + 1'b1;
    end

    always_comb begin
        sel_idx = '0;
        for (int s = int'(NUM_SLAVES) - 1; s >= 0; s--) begin
            if (SL_SEL[s]) sel_idx = SW'(s);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            split_valid_q <= 1'b0;
            split_mst_q   <= '0;
            split_slv_q   <= '0;
            ovf_q         <= 1'b0;
            grant_q       <= '0;
            msplit_q      <= '0;
            resume_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            split_valid_q <= split_valid_d;
            split_mst_q   <= split_mst_d;
            split_slv_q   <= split_slv_d;
            ovf_q         <= ovf_d;
            grant_q       <= grant_d;
            msplit_q      <= msplit_d;
            resume_q      <= resume_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        split_valid_d = split_valid_q;
        split_mst_d   = split_mst_q;
        split_slv_d   = split_slv_q;
        ovf_d         = ovf_q;
        case (state_q)
            StIdle: begin
                // A ready split slave outranks any new request.
                if (split_valid_q && slv_ready) begin
                    state_d = StResume;
                    owner_d = split_mst_q;
                end else if (|eligible) begin
                    state_d  = StGrant;
                    owner_d  = rr_pick;
                    rr_ptr_d = rr_next;
                end
            end
            StGrant: begin
                if (B_SBSY && !split_valid_q) begin
                    split_valid_d = 1'b1;
                    split_mst_d   = owner_q;
                    split_slv_d   = sel_idx;
                    state_d       = StIdle;
                end else begin
                    if (B_SBSY) ovf_d = 1'b1;
                    if (!M_REQ[owner_q]) state_d = StIdle;
                end
            end
            StResume: begin
                if (!M_REQ[split_mst_q]) begin
                    split_valid_d = 1'b0;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant_d  = (state_d == StIdle) ? '0 : mst_onehot(owner_d);
        msplit_d = split_valid_d ? mst_onehot(split_mst_d) : '0;
        resume_d = (state_d == StResume);
    end

    assign M_GRANT      = grant_q;
    assign M_SPLIT      = msplit_q;
    assign BUS_OWNER    = owner_q;
    assign B_SPLIT      = split_valid_q;
    assign B_SPL_RESUME = resume_q;
    assign SPLIT_OVF    = ovf_q;

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Randomised bench for bus_arbiter_split against a cycle-level behavioural model of
// tenures, parked splits and resumes.
module tb_bus_arbiter_split;

    localparam int NM = 2;
    localparam int NS = 3;
    localparam int MW = 1;
    localparam int SW = 2;
    localparam int ModeIdle   = 0;
    localparam int ModeTenure = 1;
    localparam int ModeResume = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic [NM-1:0] M_REQ;
    logic [NM-1:0] M_GRANT;
    logic [NM-1:0] M_SPLIT;
    logic [MW-1:0] BUS_OWNER;
    logic [NS-1:0] SL_SEL;
    logic          B_SBSY;
    logic [NS-1:0] SL_READY;
    logic          B_SPLIT;
    logic          B_SPL_RESUME;
    logic          SPLIT_OVF;

    always #5 CLK = ~CLK;

    bus_arbiter_split #(
        .NUM_MASTERS(NM),
        .NUM_SLAVES (NS),
        .MW         (MW),
        .SW         (SW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .M_REQ       (M_REQ),
        .M_GRANT     (M_GRANT),
        .M_SPLIT     (M_SPLIT),
        .BUS_OWNER   (BUS_OWNER),
        .SL_SEL      (SL_SEL),
        .B_SBSY      (B_SBSY),
        .SL_READY    (SL_READY),
        .B_SPLIT     (B_SPLIT),
        .B_SPL_RESUME(B_SPL_RESUME),
        .SPLIT_OVF   (SPLIT_OVF)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: who holds the bus, in which kind of tenure, and the one pending split.
    int mode;
    int own;
    int ptr;
    bit pend;
    int pmst;
    int pslv;
    bit ovf;
    int hold[NM];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        mode = ModeIdle;
        own  = 0;
        ptr  = 0;
        pend = 0;
        pmst = 0;
        pslv = 0;
        ovf  = 0;
    endtask

    task automatic model_step();
        int cand;
        bit picked;
        if (RST) begin
            model_reset();
            return;
        end
        case (mode)
            ModeIdle: begin
                if (pend && SL_READY[pslv]) begin
                    mode = ModeResume;
                    own  = pmst;
                end else begin
                    picked = 0;
                    for (int k = 0; k < NM; k++) begin
                        cand = (ptr + k) % NM;
                        if (!picked && M_REQ[cand] && !(pend && pmst == cand)) begin
                            picked = 1;
                            own    = cand;
                        end
                    end
                    if (picked) begin
                        mode = ModeTenure;
                        ptr  = (own + 1) % NM;
                    end
                end
            end
            ModeTenure: begin
                if (B_SBSY && !pend) begin
                    pend = 1;
                    pmst = own;
                    pslv = 0;
                    for (int s = 0; s < NS; s++) begin
                        if (SL_SEL[s]) begin
                            pslv = s;
                            break;
                        end
                    end
                    mode = ModeIdle;
                end else begin
                    if (B_SBSY) ovf = 1;
                    if (!M_REQ[own]) mode = ModeIdle;
                end
            end
            default: begin
                if (!M_REQ[pmst]) begin
                    pend = 0;
                    mode = ModeIdle;
                end
            end
        endcase
    endtask

    task automatic drive_inputs();
        bit granted;
        RST = (cyc < 3) || ($urandom_range(0, 199) == 0);
        for (int m = 0; m < NM; m++) begin
            granted = (mode != ModeIdle) && (own == m);
            if (M_REQ[m]) begin
                if (granted) begin
                    if (hold[m] > 0) hold[m]--;
                    else M_REQ[m] = 1'b0;
                end else if (pend && pmst == m && $urandom_range(0, 15) == 0) begin
                    M_REQ[m] = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                M_REQ[m] = 1'b1;
                hold[m]  = $urandom_range(1, 5);
            end
        end
        B_SBSY   = (mode == ModeTenure) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0);
        SL_SEL   = NS'($urandom_range(0, 7));
        SL_READY = NS'($urandom & $urandom);
    endtask

    task automatic compare_outputs();
        check_eq("M_GRANT", 32'(M_GRANT), (mode != ModeIdle) ? (32'd1 << own) : 32'd0);
        check_eq("M_SPLIT", 32'(M_SPLIT), pend ? (32'd1 << pmst) : 32'd0);
        check_eq("BUS_OWNER", 32'(BUS_OWNER), 32'(own));
        check_eq("B_SPLIT", 32'(B_SPLIT), 32'(pend));
        check_eq("B_SPL_RESUME", 32'(B_SPL_RESUME), 32'(mode == ModeResume));
        check_eq("SPLIT_OVF", 32'(SPLIT_OVF), 32'(ovf));
    endtask

    initial begin
        M_REQ    = '0;
        SL_SEL   = '0;
        SL_READY = '0;
        B_SBSY   = 1'b0;
        RST      = 1'b1;
        for (int m = 0; m < NM; m++) hold[m] = 0;
        model_reset();
        for (cyc = 0; cyc < 4000; cyc++) begin
            drive_inputs();
            @(posedge CLK);
            model_step();
            @(negedge CLK);
            compare_outputs();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
